// File: rtl/rvc_aligner_if.sv
// rvc_aligner_if
// Groups the fetch-side push channel, the decoder-side instruction channel,
// the redirect flush and the occupancy level of the parcel aligner.
//   slave  : seen by the aligner (takes fetch words, offers instructions)
//   master : seen by the environment (fetch unit plus decoder)
// Signals:
//   s_flush_i/s_flush_off_i         redirect and first-parcel offset after it
//   s_fetch_valid_i/_data_i/_err_i  fetch word, s_fetch_ready_o accepts it
//   s_instr_valid_o/_o/_rvc_o/_err_o instruction at head, s_instr_ready_i takes it
//   s_level_o                       parcels currently buffered
interface rvc_aligner_if #(
    parameter int FETCH_W = 32,
    parameter int DEPTH   = 8
);
    localparam int P     = FETCH_W / 16;
    localparam int OFF_W = (P > 1) ? $clog2(P) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               s_flush_i;
    logic [OFF_W-1:0]   s_flush_off_i;
    logic               s_fetch_valid_i;
    logic [FETCH_W-1:0] s_fetch_data_i;
    logic               s_fetch_err_i;
    logic               s_fetch_ready_o;
    logic               s_instr_valid_o;
    logic [31:0]        s_instr_o;
    logic               s_instr_rvc_o;
    logic               s_instr_err_o;
    logic               s_instr_ready_i;
    logic [CNT_W-1:0]   s_level_o;

    modport slave (
        input  s_flush_i, s_flush_off_i,
        input  s_fetch_valid_i, s_fetch_data_i, s_fetch_err_i,
        output s_fetch_ready_o,
        output s_instr_valid_o, s_instr_o, s_instr_rvc_o, s_instr_err_o,
        input  s_instr_ready_i,
        output s_level_o
    );

    modport master (
        output s_flush_i, s_flush_off_i,
        output s_fetch_valid_i, s_fetch_data_i, s_fetch_err_i,
        input  s_fetch_ready_o,
        input  s_instr_valid_o, s_instr_o, s_instr_rvc_o, s_instr_err_o,
        output s_instr_ready_i,
        input  s_level_o
    );
endinterface

// File: rtl/rvc_aligner.sv
// rvc_aligner
// Fetch-side parcel buffer and RV32C instruction aligner. Fetch words are
// split into 16-bit parcels held in a circular buffer together with a bus
// error bit; the head of the buffer is presented as one complete 16-bit or
// 32-bit instruction per cycle, including 32-bit instructions straddling two
// fetch words.
// Ports:
//   s_clk_i     clock, rising edge
//   s_resetn_i  asynchronous active-low reset
//   bus         rvc_aligner_if.slave: flush, fetch push channel,
//               instruction pop channel, occupancy level
module rvc_aligner #(
    parameter int FETCH_W = 32,
    parameter int DEPTH   = 8
) (
    input logic          s_clk_i,
    input logic          s_resetn_i,
    rvc_aligner_if.slave bus
);
    localparam int P     = FETCH_W / 16;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = (P > 1) ? $clog2(P) : 1;

    logic [16:0]      parcels [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [OFF_W-1:0] pend_off;
    logic             pend_vld;

    logic [16:0]      p0;
    logic [16:0]      p1;
    logic             head_rvc;
    logic             take_one;
    logic             take_two;
    logic             push;
    logic             pop;
    logic [OFF_W-1:0] push_off;
    logic [CNT_W-1:0] push_cnt;
    logic [CNT_W-1:0] pop_cnt;

    // Head decode. An errored first parcel is always issued alone so that the
    // error reaches the decoder without waiting for a second parcel that may
    // never arrive. The p1 index wraps naturally in the pointer width.
    always_comb begin
        p0       = parcels[rd_ptr];
        p1       = parcels[rd_ptr + PTR_W'(1)];
        head_rvc = (p0[1:0] != 2'b11);
        take_one = (count != '0) && (head_rvc || p0[16]);
        take_two = (count >= CNT_W'(2)) && !head_rvc && !p0[16];
    end

    // Handshakes and transfer sizes. Ready looks only at the registered count
    // so that no decoder-side input can reach the fetch side combinationally.
    // The first word after a redirect may start mid-word, so fewer parcels
    // are pushed for it.
    always_comb begin
        bus.s_fetch_ready_o = (CNT_W'(DEPTH) - count) >= CNT_W'(P);
        push     = bus.s_fetch_valid_i && bus.s_fetch_ready_o;
        pop      = (take_one || take_two) && bus.s_instr_ready_i;
        push_off = pend_vld ? pend_off : '0;
        push_cnt = push ? (CNT_W'(P) - CNT_W'(push_off)) : '0;
        pop_cnt  = pop ? (take_one ? CNT_W'(1) : CNT_W'(2)) : '0;
    end

    // Instruction channel outputs, all derived from registered state.
    always_comb begin
        bus.s_instr_valid_o = take_one || take_two;
        bus.s_instr_rvc_o   = take_one;
        bus.s_instr_o       = take_one ? {16'h0000, p0[15:0]} : {p1[15:0], p0[15:0]};
        bus.s_instr_err_o   = take_one ? p0[16] : p1[16];
        bus.s_level_o       = count;
    end

    // Parcel storage is deliberately not reset: nothing observes it while the
    // count is zero. A word offered during a flush is dropped entirely.
    always_ff @(posedge s_clk_i) begin
        if (push && !bus.s_flush_i) begin
            for (int k = 0; k < P; k++) begin
                if (k >= int'(push_off)) begin
                    parcels[wr_ptr + PTR_W'(k - int'(push_off))] <=
                        {bus.s_fetch_err_i, bus.s_fetch_data_i[16*k +: 16]};
                end
            end
        end
    end

    // Pointer, count and pending-offset bookkeeping. Flush wins over any
    // same-cycle push or pop and arms the offset for the next accepted word.
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            pend_off <= '0;
            pend_vld <= 1'b0;
        end else if (bus.s_flush_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            pend_off <= bus.s_flush_off_i;
            pend_vld <= 1'b1;
        end else begin
            rd_ptr <= rd_ptr + pop_cnt[PTR_W-1:0];
            wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
            count  <= count + push_cnt - pop_cnt;
            if (push) begin
                pend_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rvc_aligner.sv
// tb_rvc_aligner
// Self-checking bench for rvc_aligner (FETCH_W=32, DEPTH=8). The reference
// model is a queue of 17-bit parcels: pushes append parcels, the head of the
// queue decides the instruction, pops remove parcels from the front.
// Directed steps cover the documented scenarios, then a randomized run.
module tb_rvc_aligner;
    localparam int FETCH_W = 32;
    localparam int DEPTH   = 8;
    localparam int P       = FETCH_W / 16;
    localparam int OFF_W   = (P > 1) ? $clog2(P) : 1;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    logic [16:0]      mq [$];
    logic             m_pend_vld;
    logic [OFF_W-1:0] m_pend_off;

    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic        exp_rvc;
    logic        exp_err;
    int          exp_pop;

    rvc_aligner_if #(.FETCH_W(FETCH_W), .DEPTH(DEPTH)) bus ();

    rvc_aligner #(.FETCH_W(FETCH_W), .DEPTH(DEPTH)) dut (
        .s_clk_i    (clk),
        .s_resetn_i (rst_n),
        .bus        (bus)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs from the parcel queue.
    task automatic modelOutputs();
        logic [16:0] h0;
        logic [16:0] h1;
        exp_ready = (DEPTH - mq.size()) >= P;
        exp_valid = 1'b0;
        exp_instr = '0;
        exp_rvc   = 1'b0;
        exp_err   = 1'b0;
        exp_pop   = 0;
        if (mq.size() >= 1) begin
            h0 = mq[0];
            if (h0[1:0] != 2'b11 || h0[16]) begin
                exp_valid = 1'b1;
                exp_instr = {16'h0000, h0[15:0]};
                exp_rvc   = 1'b1;
                exp_err   = h0[16];
                exp_pop   = 1;
            end else if (mq.size() >= 2) begin
                h1 = mq[1];
                exp_valid = 1'b1;
                exp_instr = {h1[15:0], h0[15:0]};
                exp_rvc   = 1'b0;
                exp_err   = h1[16];
                exp_pop   = 2;
            end
        end
    endtask

    // Compares every DUT output with the model's current state.
    task automatic checkOutput();
        modelOutputs();
        checkEq("fetch_ready", {31'b0, bus.s_fetch_ready_o}, {31'b0, exp_ready});
        checkEq("level", 32'(bus.s_level_o), 32'(mq.size()));
        checkEq("instr_valid", {31'b0, bus.s_instr_valid_o}, {31'b0, exp_valid});
        if (exp_valid) begin
            checkEq("instr", bus.s_instr_o, exp_instr);
            checkEq("instr_rvc", {31'b0, bus.s_instr_rvc_o}, {31'b0, exp_rvc});
            checkEq("instr_err", {31'b0, bus.s_instr_err_o}, {31'b0, exp_err});
        end
    endtask

    // Drives one cycle of inputs, clocks it, and advances the model.
    task automatic applyStimulus(input logic fv, input logic [FETCH_W-1:0] fd, input logic fe,
                                 input logic fl, input logic [OFF_W-1:0] fo, input logic rdy);
        int popped;
        logic pushed;
        int start;
        bus.s_fetch_valid_i = fv;
        bus.s_fetch_data_i  = fd;
        bus.s_fetch_err_i   = fe;
        bus.s_flush_i       = fl;
        bus.s_flush_off_i   = fo;
        bus.s_instr_ready_i = rdy;
        modelOutputs();
        pushed = fv && exp_ready;
        popped = (exp_valid && rdy) ? exp_pop : 0;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            m_pend_vld = 1'b1;
            m_pend_off = fo;
        end else begin
            for (int i = 0; i < popped; i++) void'(mq.pop_front());
            if (pushed) begin
                start = m_pend_vld ? int'(m_pend_off) : 0;
                for (int k = start; k < P; k++) mq.push_back({fe, fd[16*k +: 16]});
                m_pend_vld = 1'b0;
            end
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_pend_vld = 1'b0;
        m_pend_off = '0;
    endtask

    // Directed scenarios followed by a randomized run against the model.
    initial begin
        rst_n = 1'b0;
        bus.s_fetch_valid_i = 1'b0;
        bus.s_fetch_data_i  = '0;
        bus.s_fetch_err_i   = 1'b0;
        bus.s_flush_i       = 1'b0;
        bus.s_flush_off_i   = '0;
        bus.s_instr_ready_i = 1'b0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput();
        checkEq("reset_ready", {31'b0, bus.s_fetch_ready_o}, 32'd1);
        checkEq("reset_level", 32'(bus.s_level_o), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput();

        $display("[TB] aligned 32-bit instruction");
        applyStimulus(1'b1, 32'h00130513, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();
        checkEq("single32", bus.s_instr_o, 32'h00130513);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();
        checkEq("single32_drained", {31'b0, bus.s_instr_valid_o}, 32'd0);

        $display("[TB] two compressed instructions");
        applyStimulus(1'b1, 32'h45014501, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();
        checkEq("rvc_first", bus.s_instr_o, 32'h00004501);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();
        checkEq("rvc_level1", 32'(bus.s_level_o), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();

        $display("[TB] straddling instruction");
        applyStimulus(1'b1, 32'h05134501, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();
        applyStimulus(1'b1, 32'h45010013, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();
        checkEq("straddle32", bus.s_instr_o, 32'h00130513);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();
        checkEq("straddle_tail", bus.s_instr_o, 32'h00004501);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();

        $display("[TB] flush with offset");
        applyStimulus(1'b1, 32'h12341234, 1'b0, 1'b1, OFF_W'(1), 1'b1);
        checkOutput();
        applyStimulus(1'b1, 32'h4501ABCD, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();
        checkEq("flush_first", bus.s_instr_o, 32'h00004501);
        checkEq("flush_level", 32'(bus.s_level_o), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();

        $display("[TB] errored word");
        applyStimulus(1'b1, 32'h00130513, 1'b1, 1'b0, '0, 1'b1);
        checkOutput();
        checkEq("err_instr", bus.s_instr_o, 32'h00000513);
        checkEq("err_flag", {31'b0, bus.s_instr_err_o}, 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();
        checkEq("err_one_parcel", 32'(bus.s_level_o), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();

        $display("[TB] full buffer");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h45014501, 1'b0, 1'b0, '0, 1'b0);
            checkOutput();
        end
        checkEq("full_ready", {31'b0, bus.s_fetch_ready_o}, 32'd0);
        checkEq("full_level", 32'(bus.s_level_o), 32'd8);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();
        checkEq("level7_ready", {31'b0, bus.s_fetch_ready_o}, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput();
        checkEq("level6_ready", {31'b0, bus.s_fetch_ready_o}, 32'd1);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b1, 32'h45014501, 1'b0, 1'b1, '0, 1'b0);
        modelReset();
        applyStimulus(1'b1, 32'h45014501, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h45014501, 1'b0, 1'b0, '0, 1'b0);
        checkOutput();
        checkEq("pre_reset_level", 32'(bus.s_level_o), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkEq("async_level", 32'(bus.s_level_o), 32'd0);
        checkOutput();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] randomized run");
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 9) < 7), FETCH_W'($urandom),
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                          OFF_W'($urandom_range(0, P - 1)), ($urandom_range(0, 9) < 7));
            checkOutput();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rvc_aligner.md
# rvc_aligner

Parametrised fetch-side parcel buffer and instruction aligner. It accepts fetch words of FETCH_W bits and splits them into 16-bit parcels, which it holds in a circular buffer. It presents one complete RV32C instruction per cycle: either a 16-bit parcel or a 32-bit pair that may straddle two fetch words. The block sits between the fetch interface and the RVC/RV32 decoders, and the decoders consume its s_instr_o/s_instr_rvc_o.

## Interface
- FETCH_W, 32: fetch word width; 32 or 64. P = FETCH_W/16 parcels per word.
- DEPTH, 8: buffer depth in parcels; power of two, ≥ 2·P.

Reset is asynchronous and active-low; one clock.
- s_clk_i  in  1  clock, rising edge
- s_resetn_i  in  1  asynchronous active-low reset
- s_flush_i  in  1  discard all buffered parcels (redirect)
- s_flush_off_i  in  log2(P) (min 1)  parcel offset of the first valid parcel in the first word accepted after flush
- s_fetch_valid_i  in  1  fetch word present
- s_fetch_data_i  in  FETCH_W  fetch word; parcel k = bits[16k+15:16k]
- s_fetch_err_i  in  1  bus error for this word
- s_fetch_ready_o  out  1  word may be accepted
- s_instr_valid_o  out  1  complete instruction at head
- s_instr_o  out  32  instruction; upper 16 bits zero when compressed
- s_instr_rvc_o  out  1  instruction is 16-bit
- s_instr_err_o  out  1  instruction contains an errored parcel
- s_instr_ready_i  in  1  consumer takes instruction
- s_level_o  out  log2(DEPTH)+1  parcels held

## Operation
- State:
  - parcel array [DEPTH] × 17 bits (16 data + err);
  - rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - count, log2(DEPTH)+1 bits;
  - pend_off register plus pend_vld flag.
- Push (s_fetch_valid_i & s_fetch_ready_o):
  - off = pend_vld ? pend_off : 0.
  - Parcels off..P-1 are written in order at wr_ptr; wr_ptr += P-off.
  - All written parcels take err = s_fetch_err_i.
  - pend_vld clears.
- s_fetch_ready_o = (DEPTH - count) ≥ P. It is computed from registered count only; same-cycle pop does not count.
- Head parcel p0 = array[rd_ptr]; p1 = array[rd_ptr+1].
- Head is compressed when p0[1:0] ≠ 2'b11.
- Output decode:
  - Case A: count ≥ 1 and (compressed or p0.err).
    - s_instr_valid_o=1, s_instr_o={16'h0,p0}, s_instr_rvc_o=1, s_instr_err_o=p0.err.
    - Pop size 1.
  - Case B: count ≥ 2, not compressed, p0.err=0.
    - s_instr_valid_o=1, s_instr_o={p1,p0}, s_instr_rvc_o=0, s_instr_err_o=p1.err.
    - Pop size 2.
  - Otherwise s_instr_valid_o=0 (includes count=1 with an uncompressed, error-free p0). s_instr_o, s_instr_rvc_o and s_instr_err_o are then don't-care.
- Pop (s_instr_valid_o & s_instr_ready_i): rd_ptr += pop size.
- Count update: count_next = count + pushed − popped. Simultaneous push and pop are both applied in the same cycle.
- Flush, highest priority:
  - rd_ptr, wr_ptr and count go to 0.
  - pend_off ← s_flush_off_i; pend_vld ← 1.
  - Any same-cycle push and pop are discarded. s_fetch_ready_o may still be high; the word is dropped, and the fetch unit re-issues it after redirect.
- s_level_o = count.
- Reset values:
  - count=0, pointers 0, pend_vld=0, pend_off=0.
  - s_fetch_ready_o=1, s_instr_valid_o=0, s_level_o=0.
  - Array contents are not reset; valid never depends on them while count=0.

## Timing
- All outputs derive combinationally from registered state. There is no input-to-output combinational path except s_fetch_ready_o ← count.
- Push to s_instr_valid_o: 1 cycle.
- A straddling 32-bit instruction becomes valid 1 cycle after the word carrying its upper parcel is accepted.
- Steady throughput: one instruction per cycle while s_instr_ready_i=1 and the buffer is not starved.
- Wrap-around: p1 is read at (rd_ptr+1) mod DEPTH.
- Full: count = DEPTH − P + 1 … DEPTH ⇒ s_fetch_ready_o=0.
- Reset asserted mid-operation: state clears asynchronously, and outputs take reset values in the same cycle.

## Test plan
- Reset, then release with no stimulus:
  - s_fetch_ready_o=1, s_instr_valid_o=0, s_level_o=0.
  - Reassert reset with count=4: s_level_o=0 immediately.
- FETCH_W=32, push 0x00130513, s_instr_ready_i=1:
  - Next cycle valid, s_instr_o=0x00130513, rvc=0.
  - Following cycle valid=0, level=0.
- Push 0x45014501:
  - Two consecutive instructions 0x00004501 with rvc=1.
  - level goes 2 → 1 → 0.
- Straddle: push 0x05134501, then 0x45010013. Outputs in order:
  - 0x00004501 (rvc);
  - 0x00130513 (rvc=0), valid one cycle after the second push;
  - 0x00004501.
- Flush with s_flush_off_i=1, then push 0x4501ABCD:
  - Only 0x00004501 is emitted; 0xABCD is discarded.
  - A word offered in the flush cycle itself is never emitted.
- Errors and full buffer:
  - Push with s_fetch_err_i=1, word 0x00130513: one 16-bit instruction 0x00000513 with err=1, consuming one parcel.
  - Hold s_instr_ready_i=0 and push 4 words (DEPTH=8): s_fetch_ready_o=0 at level 8, reasserts after two pops.
